// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIX,
        DIV_DONE
    } e_div_state;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WORD = 8
) (
    input  logic [WORD-1:0] i_prem,
    input  logic            i_bit,
    input  logic [WORD-1:0] i_divisor,
    output logic [WORD-1:0] o_prem,
    output logic            o_qbit
);

    logic [WORD:0] w_shift;
    logic [WORD:0] w_trial;

    assign w_shift = {i_prem, i_bit};
    // prem < divisor holds on entry, so the WORD+1-bit difference cannot wrap.
    assign w_trial = w_shift - {1'b0, i_divisor};
    assign o_qbit  = ~w_trial[WORD];
    assign o_prem  = o_qbit ? w_trial[WORD-1:0] : w_shift[WORD-1:0];

endmodule

// File: rtl/alu_divider_seq.sv
// Multi-cycle restoring divider (signed/unsigned) with truncating quotient and
// dividend-signed remainder; one quotient bit per CALC cycle.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  DIV_IDLE | ready, waiting for start; operands and sign flags latched on start
//  DIV_CALC | WORD restoring steps on magnitudes
//  DIV_FIX  | apply result signs, register quotient/remainder/flags
//  DIV_DONE | done pulse, results valid; start ignored this cycle
module alu_divider_seq
    import alu_pkg::*;
#(
    parameter int WORD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            sign,
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [WORD-1:0] quotient,
    output logic [WORD-1:0] remainder,
    output logic            div_zero,
    output logic            overflow
);

    localparam int              CNTW     = $clog2(WORD) + 1;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(WORD);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(1);
    localparam logic [WORD-1:0] MOST_NEG = {1'b1, {(WORD-1){1'b0}}};

    e_div_state      r_state;
    e_div_state      w_next;
    logic [CNTW-1:0] r_cnt;
    logic [WORD-1:0] r_prem;
    logic [WORD-1:0] r_dvd;
    logic [WORD-1:0] r_dvs;
    logic [WORD-1:0] r_q;
    logic [WORD-1:0] r_quotient;
    logic [WORD-1:0] r_remainder;
    logic            r_qneg;
    logic            r_rneg;
    logic            r_ovf;
    logic            r_div_zero;
    logic            r_overflow;

    logic            w_a_neg;
    logic            w_b_neg;
    logic [WORD-1:0] w_amag;
    logic [WORD-1:0] w_bmag;
    logic            w_b_zero;
    logic            w_is_ovf;
    logic [WORD-1:0] w_prem_next;
    logic            w_qbit;

    assign w_a_neg  = sign & a[WORD-1];
    assign w_b_neg  = sign & b[WORD-1];
    assign w_amag   = w_a_neg ? -a : a;
    assign w_bmag   = w_b_neg ? -b : b;
    assign w_b_zero = (b == '0);
    assign w_is_ovf = sign & (a == MOST_NEG) & (b == '1);

    div_step #(
        .WORD (WORD)
    ) u_div_step (
        .i_prem    (r_prem),
        .i_bit     (r_dvd[WORD-1]),
        .i_divisor (r_dvs),
        .o_prem    (w_prem_next),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DIV_IDLE: begin
                if (start) begin
                    w_next = w_b_zero ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_next = DIV_FIX;
                end
            end
            DIV_FIX:  w_next = DIV_DONE;
            DIV_DONE: w_next = DIV_IDLE;
            default:  w_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_prem      <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_q         <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_ovf       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_dvd  <= w_amag;
                        r_dvs  <= w_bmag;
                        r_qneg <= sign & (a[WORD-1] ^ b[WORD-1]);
                        r_rneg <= w_a_neg;
                        r_ovf  <= w_is_ovf;
                        r_prem <= '0;
                        r_q    <= '0;
                        r_cnt  <= CNT_LOAD;
                        // Divide-by-zero skips CALC; results become visible in DONE.
                        if (w_b_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= a;
                            r_div_zero  <= 1'b1;
                            r_overflow  <= 1'b0;
                        end
                    end
                end
                DIV_CALC: begin
                    r_prem <= w_prem_next;
                    r_q    <= {r_q[WORD-2:0], w_qbit};
                    r_dvd  <= {r_dvd[WORD-2:0], 1'b0};
                    r_cnt  <= r_cnt - 1'b1;
                end
                DIV_FIX: begin
                    // Most-negative / -1 wraps naturally to most-negative, remainder 0.
                    r_quotient  <= r_qneg ? -r_q : r_q;
                    r_remainder <= r_rneg ? -r_prem : r_prem;
                    r_div_zero  <= 1'b0;
                    r_overflow  <= r_ovf;
                end
                default: begin
                end
            endcase
        end
    end

    assign ready     = (r_state == DIV_IDLE);
    assign busy      = ~ready;
    assign done      = (r_state == DIV_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;
    assign overflow  = r_overflow;

endmodule
